// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, probes the I-cache, refills on miss from memory and hands words
// to the decoder over valid/ready. Optional static JAL prediction under IFETCH_JAL_PREDICT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] icache_addr,
  input  logic        icache_hit,
  input  logic [31:0] icache_result,
  output logic        icache_wr,
  output logic [31:0] icache_value,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_pred_taken
);

  typedef enum logic {Fetch, Miss} state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] miss_addr;
  logic        discard;
  logic        fill_pending;

  logic        slot_free;
  logic [31:0] dlv_word;
  logic [31:0] dlv_pc;
  logic [31:0] next_pc;
  logic        dlv_jal;

  assign icache_addr = (state == Miss) ? miss_addr : pc;
  // A frozen pipeline must never write the cache, even mid-fill.
  assign icache_wr   = fill_pending & rdy_in;
  assign slot_free   = !inst_valid || inst_ready;
  assign dlv_word    = (state == Miss) ? mem_data : icache_result;
  assign dlv_pc      = (state == Miss) ? miss_addr : pc;

`ifdef IFETCH_JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign dlv_jal = (dlv_word[6:0] == 7'b1101111);
  assign jal_imm = {{11{dlv_word[31]}}, dlv_word[31], dlv_word[19:12], dlv_word[20],
                    dlv_word[30:21], 1'b0};
  assign next_pc = dlv_jal ? (dlv_pc + jal_imm) : (dlv_pc + 32'd4);
`else
  assign dlv_jal = 1'b0;
  assign next_pc = dlv_pc + 32'd4;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= Fetch;
      pc              <= RESET_PC;
      miss_addr       <= 32'h0;
      discard         <= 1'b0;
      fill_pending    <= 1'b0;
      icache_value    <= 32'h0;
      mem_req         <= 1'b0;
      mem_addr        <= 32'h0;
      inst_valid      <= 1'b0;
      inst            <= 32'h0;
      inst_pc         <= 32'h0;
      inst_pred_taken <= 1'b0;
    end else if (rdy_in) begin
      if (inst_valid && inst_ready) begin
        inst_valid <= 1'b0;
      end
      unique case (state)
        Fetch: begin
          if (!flush && slot_free) begin
            if (icache_hit) begin
              inst            <= dlv_word;
              inst_pc         <= dlv_pc;
              inst_pred_taken <= dlv_jal;
              inst_valid      <= 1'b1;
              pc              <= next_pc;
            end else begin
              miss_addr <= pc;
              mem_addr  <= pc;
              mem_req   <= 1'b1;
              state     <= Miss;
            end
          end
        end
        Miss: begin
          if (fill_pending) begin
            fill_pending <= 1'b0;
            state        <= Fetch;
          end else if (mem_done) begin
            mem_req      <= 1'b0;
            fill_pending <= 1'b1;
            icache_value <= mem_data;
            discard      <= 1'b0;
            // Word always lands in the cache; a busy slot just means it is re-fetched as a hit.
            if (!flush && !discard && slot_free) begin
              inst            <= dlv_word;
              inst_pc         <= dlv_pc;
              inst_pred_taken <= dlv_jal;
              inst_valid      <= 1'b1;
              pc              <= next_pc;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= Fetch;
      endcase
      if (flush) begin
        pc         <= flush_pc;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small behavioural I-cache model and a hand-driven
// memory port; JAL expectations follow IFETCH_JAL_PREDICT_EN.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] icache_addr;
  logic        icache_hit;
  logic [31:0] icache_result;
  logic        icache_wr;
  logic [31:0] icache_value;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_taken;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .rdy_in          (rdy_in),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .icache_addr     (icache_addr),
    .icache_hit      (icache_hit),
    .icache_result   (icache_result),
    .icache_wr       (icache_wr),
    .icache_value    (icache_value),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_done        (mem_done),
    .mem_data        (mem_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_pred_taken (inst_pred_taken)
  );

  always #5 clk = ~clk;

  // Direct-mapped cache model, 256 lines with full-address tags; a few lines preloaded on reset.
  logic [31:0] c_tag [256];
  logic [31:0] c_dat [256];
  logic        c_vld [256];
  logic [7:0]  c_idx;

  assign c_idx         = icache_addr[9:2];
  assign icache_hit    = c_vld[c_idx] && (c_tag[c_idx] == icache_addr);
  assign icache_result = c_dat[c_idx];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        c_vld[i] <= 1'b0;
        c_tag[i] <= 32'h0;
        c_dat[i] <= 32'h0;
      end
      c_vld[8'h08] <= 1'b1; c_tag[8'h08] <= 32'h20;       c_dat[8'h08] <= 32'h0100006F;
      c_vld[8'h09] <= 1'b1; c_tag[8'h09] <= 32'h24;       c_dat[8'h09] <= 32'h00000013;
      c_vld[8'h0C] <= 1'b1; c_tag[8'h0C] <= 32'h30;       c_dat[8'h0C] <= 32'h00000013;
      c_vld[8'hFF] <= 1'b1; c_tag[8'hFF] <= 32'hFFFFFFFC; c_dat[8'hFF] <= 32'h00000013;
    end else if (icache_wr) begin
      c_vld[c_idx] <= 1'b1;
      c_tag[c_idx] <= icache_addr;
      c_dat[c_idx] <= icache_value;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef IFETCH_JAL_PREDICT_EN
  localparam logic [31:0] JalNext = 32'h30;
  localparam logic        JalPred = 1'b1;
`else
  localparam logic [31:0] JalNext = 32'h24;
  localparam logic        JalPred = 1'b0;
`endif

  initial begin
    rst = 1'b1; rdy_in = 1'b1; flush = 1'b0; flush_pc = 32'h0;
    mem_done = 1'b0; mem_data = 32'h0; inst_ready = 1'b1;
    tick(); tick();
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_icache_wr", {31'h0, icache_wr}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_icache_addr", icache_addr, 32'h0);

    // Cold miss at 0
    rst = 1'b0;
    tick();
    check("miss0_req", {31'h0, mem_req}, 32'h1);
    check("miss0_addr", mem_addr, 32'h0);
    tick();
    check("miss0_req_held", {31'h0, mem_req}, 32'h1);
    mem_done = 1'b1; mem_data = 32'h00000013;
    tick();
    mem_done = 1'b0;
    check("fill0_wr", {31'h0, icache_wr}, 32'h1);
    check("fill0_value", icache_value, 32'h00000013);
    check("fill0_addr", icache_addr, 32'h0);
    check("fill0_valid", {31'h0, inst_valid}, 32'h1);
    check("fill0_inst", inst, 32'h00000013);
    check("fill0_pc", inst_pc, 32'h0);
    check("fill0_req_drop", {31'h0, mem_req}, 32'h0);
    tick();
    check("fill0_wr_once", {31'h0, icache_wr}, 32'h0);
    check("after0_addr", icache_addr, 32'h4);
    tick();
    check("miss4_req", {31'h0, mem_req}, 32'h1);
    check("miss4_addr", mem_addr, 32'h4);

    // Flush back to 0 while missing at 4: fill happens, word dropped
    flush = 1'b1; flush_pc = 32'h0;
    tick();
    flush = 1'b0;
    check("fl4_valid", {31'h0, inst_valid}, 32'h0);
    check("fl4_req", {31'h0, mem_req}, 32'h1);
    check("fl4_icache_addr", icache_addr, 32'h4);
    mem_done = 1'b1; mem_data = 32'h00400093;
    tick();
    mem_done = 1'b0;
    check("fl4_fill_wr", {31'h0, icache_wr}, 32'h1);
    check("fl4_fill_value", icache_value, 32'h00400093);
    check("fl4_no_deliver", {31'h0, inst_valid}, 32'h0);
    tick();
    check("fl4_back_fetch", icache_addr, 32'h0);
    tick();
    check("hit0_valid", {31'h0, inst_valid}, 32'h1);
    check("hit0_inst", inst, 32'h00000013);
    check("hit0_pc", inst_pc, 32'h0);
    check("hit0_no_req", {31'h0, mem_req}, 32'h0);

    // Decoder stall for 3 cycles
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_inst", inst, 32'h00000013);
      check("stall_pc", inst_pc, 32'h0);
      check("stall_fetch_pc", icache_addr, 32'h4);
    end
    inst_ready = 1'b1;
    tick();
    check("unstall_valid", {31'h0, inst_valid}, 32'h1);
    check("unstall_inst", inst, 32'h00400093);
    check("unstall_pc", inst_pc, 32'h4);
    tick();
    check("miss8_valid", {31'h0, inst_valid}, 32'h0);
    check("miss8_addr", mem_addr, 32'h8);

    // Flush to 0x100 while missing at 8
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    tick();
    check("fl8_req_held", {31'h0, mem_req}, 32'h1);
    mem_done = 1'b1; mem_data = 32'hDEADBEEF;
    tick();
    mem_done = 1'b0;
    check("fl8_fill_wr", {31'h0, icache_wr}, 32'h1);
    check("fl8_fill_addr", icache_addr, 32'h8);
    check("fl8_no_deliver", {31'h0, inst_valid}, 32'h0);
    tick();
    check("fl8_still_idle", {31'h0, inst_valid}, 32'h0);
    tick();
    check("miss100_req", {31'h0, mem_req}, 32'h1);
    check("miss100_addr", mem_addr, 32'h100);

    // Freeze with a completion pulse that must be ignored
    rdy_in = 1'b0; mem_done = 1'b1; mem_data = 32'h11111111;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_done = 1'b0;
      check("frz_wr", {31'h0, icache_wr}, 32'h0);
      check("frz_req", {31'h0, mem_req}, 32'h1);
      check("frz_valid", {31'h0, inst_valid}, 32'h0);
    end
    check("frz_addr", mem_addr, 32'h100);
    rdy_in = 1'b1;
    tick();
    check("resume_req", {31'h0, mem_req}, 32'h1);
    mem_done = 1'b1; mem_data = 32'h00000113;
    tick();
    mem_done = 1'b0;
    check("resume_wr", {31'h0, icache_wr}, 32'h1);
    check("resume_valid", {31'h0, inst_valid}, 32'h1);
    check("resume_inst", inst, 32'h00000113);
    check("resume_pc", inst_pc, 32'h100);

    // JAL +16 at 0x20
    flush = 1'b1; flush_pc = 32'h20;
    tick();
    flush = 1'b0;
    check("jal_flush_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    check("jal_inst", inst, 32'h0100006F);
    check("jal_pc", inst_pc, 32'h20);
    check("jal_pred", {31'h0, inst_pred_taken}, {31'h0, JalPred});
    check("jal_next_fetch", icache_addr, JalNext);
    tick();
    check("jal_target_pc", inst_pc, JalNext);
    check("jal_target_pred", {31'h0, inst_pred_taken}, 32'h0);

    // PC wraps modulo 2^32
    flush = 1'b1; flush_pc = 32'hFFFFFFFC;
    tick();
    flush = 1'b0;
    tick();
    check("wrap_pc", inst_pc, 32'hFFFFFFFC);
    check("wrap_next", icache_addr, 32'h0);

    // Asynchronous reset in the middle of a miss
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    tick();
    check("miss200_req", {31'h0, mem_req}, 32'h1);
    check("miss200_addr", mem_addr, 32'h200);
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'h0, mem_req}, 32'h0);
    check("arst_addr", icache_addr, 32'h0);
    check("arst_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
